// File: rtl/mac_pkg.sv
// Shared types and constants for the transmit MAC framer.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT     = 32'hFFFFFFFF;

endpackage

// File: rtl/mac_lfsr.sv
// Combinational Galois-form CRC/LFSR step: advances the state by DATA_W input
// bits in one cycle. REVERSED selects LSB-first (reflected) processing.
module mac_lfsr #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DATA_W   = 8,
    parameter logic [WIDTH-1:0] POLY     = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] INIT     = '1,
    parameter logic [WIDTH-1:0] XOR_OUT  = '1,
    parameter bit               REVERSED = 1'b1
) (
    input  logic              clear,
    input  logic [WIDTH-1:0]  state_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [WIDTH-1:0]  state_out,
    output logic [WIDTH-1:0]  crc_out
);

    function automatic logic [WIDTH-1:0] reflect(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] POLY_REV = reflect(POLY);

    logic [WIDTH-1:0] s;
    logic             fb;

    // Bit-serial Galois update unrolled over the data word; clear reseeds.
    always_comb begin
        s  = state_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (REVERSED) begin
                fb = s[0] ^ data_in[i];
                s  = s >> 1;
                if (fb) s = s ^ POLY_REV;
            end else begin
                fb = s[WIDTH-1] ^ data_in[DATA_W-1-i];
                s  = s << 1;
                if (fb) s = s ^ POLY;
            end
        end
        state_out = clear ? INIT : s;
    end

    assign crc_out = state_in ^ XOR_OUT;

endmodule

// File: rtl/mac_tx_fcs_insert.sv
// Transmit MAC framer: preamble/SFD, payload, optional zero pad, CRC-32 FCS
// and enforced inter-frame gap onto a GMII-style byte stream.
// Build option: define MAC_TX_PAD_EN to pad short frames to MIN_FRAME_BYTES.
module mac_tx_fcs_insert
    import mac_pkg::*;
#(
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_BYTES       = 12,
    parameter int unsigned PREAMBLE_BYTES  = 7
) (
    input  logic       phy_tx_clk,
    input  logic       phy_tx_rst,
    input  logic [7:0] mac_tdata_in,
    input  logic       mac_tvalid_in,
    output logic       mac_tready_out,
    input  logic       mac_tlast_in,
    output logic [7:0] phy_txd_out,
    output logic       phy_tvalid_out,
    output logic       phy_terr_out
);

`ifdef MAC_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [16:0] MIN17    = 17'(MIN_FRAME_BYTES);
    localparam logic [7:0]  PRE_LEN  = 8'(PREAMBLE_BYTES);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    tx_state_t   state_q, state_d;
    logic [7:0]  txd_q, txd_d;
    logic        tvalid_q, tvalid_d;
    logic        terr_q, terr_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [1:0]  fcs_cnt_q, fcs_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [31:0] crc_q, crc_next, crc_fcs;
    logic        crc_clear, crc_step;
    logic [7:0]  crc_data;
    logic [16:0] byte_cnt_inc;
    logic        below_min;

    assign byte_cnt_inc   = {1'b0, byte_cnt_q} + 17'd1;
    assign below_min      = byte_cnt_inc < MIN17;
    assign mac_tready_out = (state_q == DATA);

    mac_lfsr #(
        .WIDTH    (32),
        .DATA_W   (8),
        .POLY     (CRC32_POLY),
        .INIT     (CRC32_INIT),
        .XOR_OUT  (CRC32_XOR_OUT),
        .REVERSED (1'b1)
    ) u_crc (
        .clear     (crc_clear),
        .state_in  (crc_q),
        .data_in   (crc_data),
        .state_out (crc_next),
        .crc_out   (crc_fcs)
    );

    // Next-state, next-output and counter updates for the framing FSM.
    // IDLE already loads the first preamble byte so the stream has no gap.
    always_comb begin
        state_d    = state_q;
        txd_d      = '0;
        tvalid_d   = 1'b0;
        terr_d     = 1'b0;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        fcs_cnt_d  = fcs_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        crc_clear  = 1'b0;
        crc_step   = 1'b0;
        crc_data   = mac_tdata_in;
        case (state_q)
            IDLE: begin
                if (mac_tvalid_in) begin
                    txd_d      = ETH_PREAMBLE_BYTE;
                    tvalid_d   = 1'b1;
                    pre_cnt_d  = 8'd1;
                    byte_cnt_d = '0;
                    crc_clear  = 1'b1;
                    state_d    = PRE;
                end
            end
            PRE: begin
                tvalid_d = 1'b1;
                if (pre_cnt_q < PRE_LEN) begin
                    txd_d     = ETH_PREAMBLE_BYTE;
                    pre_cnt_d = pre_cnt_q + 8'd1;
                end else begin
                    txd_d   = ETH_SFD;
                    state_d = DATA;
                end
            end
            DATA: begin
                tvalid_d = 1'b1;
                if (mac_tvalid_in) begin
                    txd_d    = mac_tdata_in;
                    crc_step = 1'b1;
                    if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 16'd1;
                    if (mac_tlast_in) begin
                        fcs_cnt_d = '0;
                        state_d   = (PAD_EN && below_min) ? PAD : FCS;
                    end
                end else begin
                    terr_d    = 1'b1;
                    ifg_cnt_d = '0;
                    state_d   = IFG;
                end
            end
`ifdef MAC_TX_PAD_EN
            PAD: begin
                tvalid_d   = 1'b1;
                crc_data   = 8'h00;
                crc_step   = 1'b1;
                byte_cnt_d = byte_cnt_inc[15:0];
                if (!below_min) begin
                    fcs_cnt_d = '0;
                    state_d   = FCS;
                end
            end
`endif
            FCS: begin
                tvalid_d = 1'b1;
                txd_d    = crc_fcs[{fcs_cnt_q, 3'b000} +: 8];
                if (fcs_cnt_q == 2'd3) begin
                    ifg_cnt_d = '0;
                    state_d   = IFG;
                end else begin
                    fcs_cnt_d = fcs_cnt_q + 2'd1;
                end
            end
            IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, CRC and registered PHY outputs.
    always_ff @(posedge phy_tx_clk or posedge phy_tx_rst) begin
        if (phy_tx_rst) begin
            state_q    <= IDLE;
            txd_q      <= '0;
            tvalid_q   <= 1'b0;
            terr_q     <= 1'b0;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            fcs_cnt_q  <= '0;
            ifg_cnt_q  <= '0;
            crc_q      <= CRC32_INIT;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            tvalid_q   <= tvalid_d;
            terr_q     <= terr_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            fcs_cnt_q  <= fcs_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
            if (crc_clear || crc_step) crc_q <= crc_next;
        end
    end

    assign phy_txd_out    = txd_q;
    assign phy_tvalid_out = tvalid_q;
    assign phy_terr_out   = terr_q;

endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
// Self-checking bench for mac_tx_fcs_insert (honours MAC_TX_PAD_EN if defined).
module tb_mac_tx_fcs_insert;

`ifdef MAC_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata = '0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       tready;
    logic [7:0] txd;
    logic       txv;
    logic       terr;

    mac_tx_fcs_insert #(
        .MIN_FRAME_BYTES (60),
        .IFG_BYTES       (12),
        .PREAMBLE_BYTES  (7)
    ) dut (
        .phy_tx_clk     (clk),
        .phy_tx_rst     (rst),
        .mac_tdata_in   (tdata),
        .mac_tvalid_in  (tvalid),
        .mac_tready_out (tready),
        .mac_tlast_in   (tlast),
        .phy_txd_out    (txd),
        .phy_tvalid_out (txv),
        .phy_terr_out   (terr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] txd;
        logic       terr;
        bit         first;
        bit         last;
    } obs_t;

    typedef struct {
        string      name;
        int         len;
        logic [7:0] seed;
        int         underrun_at;
        int         exp_run;
        logic [31:0] exp_tail;
    } vec_t;

    obs_t        exp_q[$];
    vec_t        vecs[$];
    int          runs[$];
    int          gaps[$];
    logic [31:0] tails[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic e, input bit f, input bit l);
        obs_t o;
        o.txd = d; o.terr = e; o.first = f; o.last = l;
        exp_q.push_back(o);
    endtask

    // Reference frame: preamble, SFD, payload, optional pad, FCS or error byte.
    task automatic push_frame(input int len, input logic [7:0] seed, input int underrun_at);
        logic [31:0] c;
        logic [7:0]  b;
        int          n, total;
        for (int i = 0; i < 7; i++) push_exp(8'h55, 1'b0, i == 0, 1'b0);
        push_exp(8'hD5, 1'b0, 1'b0, 1'b0);
        c = 32'hFFFFFFFF;
        n = (underrun_at >= 0) ? underrun_at : len;
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i);
            push_exp(b, 1'b0, 1'b0, 1'b0);
            c = crc_byte(c, b);
        end
        if (underrun_at >= 0) begin
            push_exp(8'h00, 1'b1, 1'b0, 1'b1);
        end else begin
            total = len;
            while (PAD_ON && total < 60) begin
                push_exp(8'h00, 1'b0, 1'b0, 1'b0);
                c = crc_byte(c, 8'h00);
                total++;
            end
            c = ~c;
            for (int k = 0; k < 4; k++) push_exp(c[8*k +: 8], 1'b0, 1'b0, k == 3);
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] seed, input int underrun_at);
        bit ok;
        int waited;
        push_frame(len, seed, underrun_at);
        for (int i = 0; i < len; i++) begin
            if (i == underrun_at) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                @(posedge clk); #1;
                return;
            end
            tdata  = seed + 8'(i);
            tlast  = (i == len - 1);
            tvalid = 1'b1;
            waited = 0;
            ok     = 1'b0;
            do begin
                @(negedge clk);
                ok = tready;
                @(posedge clk); #1;
                waited++;
            end while (!ok && waited < 200);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL handshake_timeout: got no ready within %0d cycles required ready", waited);
                tvalid = 1'b0;
                return;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (extra) @(negedge clk);
        #1;
    endtask

    task automatic add_vec(input string nm, input int len, input logic [7:0] seed,
                           input int ua, input int run, input logic [31:0] tail);
        vec_t v;
        v.name = nm; v.len = len; v.seed = seed; v.underrun_at = ua;
        v.exp_run = run; v.exp_tail = tail;
        vecs.push_back(v);
    endtask

    // Output monitor: scoreboard compare, run lengths, FCS tails, inter-frame gaps.
    int          cyc = 0;
    int          run_len = 0;
    bit          in_run = 1'b0;
    int          prev_last_cyc = -1;
    logic [31:0] last4 = '0;
    always @(negedge clk) begin
        obs_t e;
        cyc++;
        if (rst !== 1'b0) begin
            in_run = 1'b0; run_len = 0; prev_last_cyc = -1;
        end else if (txv) begin
            run_len++;
            in_run = 1'b1;
            last4  = {txd, last4[31:8]};
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_byte: got %0h with nothing expected", txd);
            end else begin
                e = exp_q.pop_front();
                chk("txd", 32'(txd), 32'(e.txd));
                chk("terr", 32'(terr), 32'(e.terr));
                if (e.first && prev_last_cyc >= 0) gaps.push_back(cyc - prev_last_cyc);
                if (e.last) prev_last_cyc = cyc;
            end
        end else begin
            if (in_run) begin
                runs.push_back(run_len);
                tails.push_back(last4);
            end
            in_run = 1'b0;
            run_len = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec("ascii9",   9,  8'h31, -1, 21, 32'hCBF43926);
        add_vec("one_byte", 1,  8'h01, -1, PAD_ON ? 72 : 13, 32'h0);
        add_vec("len59",    59, 8'h10, -1, PAD_ON ? 72 : 71, 32'h0);
        add_vec("len60",    60, 8'h20, -1, 72, 32'h0);
        add_vec("len64_a",  64, 8'h40, -1, 76, 32'h0);
        add_vec("len64_b",  64, 8'h80, -1, 76, 32'h0);
        add_vec("underrun", 20, 8'hA0, 10, 19, 32'h0);
        add_vec("ascii9_2", 9,  8'h31, -1, 21, 32'hCBF43926);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'h0);
        chk("reset_tvalid", 32'(txv), 32'h0);
        chk("reset_terr", 32'(terr), 32'h0);
        chk("reset_tready", 32'(tready), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tready", 32'(tready), 32'h0);
        chk("idle_tvalid", 32'(txv), 32'h0);

        // Back-to-back frames from the table; each starts as soon as the last ends.
        foreach (vecs[i]) send_frame(vecs[i].len, vecs[i].seed, vecs[i].underrun_at);
        drain(16);

        chk("run_count", 32'(runs.size()), 32'(vecs.size()));
        chk("gap_count", 32'(gaps.size()), 32'(vecs.size() - 1));
        foreach (vecs[i]) begin
            if (i < runs.size()) begin
                chk({"run_", vecs[i].name}, 32'(runs[i]), 32'(vecs[i].exp_run));
                if (vecs[i].exp_tail != 32'h0)
                    chk({"fcs_", vecs[i].name}, tails[i], vecs[i].exp_tail);
            end
            if (i > 0 && i - 1 < gaps.size())
                chk({"gap_before_", vecs[i].name}, 32'(gaps[i-1]), 32'd13);
        end

        // Reset asserted while the FCS is on the wire.
        runs.delete(); gaps.delete(); tails.delete();
        send_frame(9, 8'h31, -1);
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 2 && guard < 100) begin
                @(negedge clk); #1;
                guard++;
            end
        end
        chk("pre_reset_in_fcs", 32'(exp_q.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("midreset_tvalid", 32'(txv), 32'h0);
        chk("midreset_txd", 32'(txd), 32'h0);
        chk("midreset_terr", 32'(terr), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        runs.delete(); gaps.delete(); tails.delete();
        @(negedge clk);
        chk("post_reset_tvalid", 32'(txv), 32'h0);
        send_frame(9, 8'h31, -1);
        drain(4);
        chk("post_reset_run_count", 32'(runs.size()), 32'd1);
        if (runs.size() > 0) begin
            chk("post_reset_run", 32'(runs[0]), 32'd21);
            chk("post_reset_fcs", tails[0], 32'hCBF43926);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
